// File: rtl/wavetable_if.sv
// AXI-stream style handshake bundle used for both the frequency input and the
// sample output of the wavetable synthesizer.
interface Axis_If #(
  parameter int DWIDTH = 24
);
  logic [DWIDTH-1:0] data;
  logic              valid;
  logic              ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/wavetable.sv
// DDS sine generator: a fractional sample-rate strobe steps a phase accumulator
// whose top bits address a sine ROM built at elaboration.
module wavetable #(
  parameter int CLK_RATE_HZ    = 100_000_000,
  parameter int SAMPLE_RATE_HZ = 48_000,
  parameter int PHASE_BITS     = 32,
  parameter int LUT_BITS       = 10
) (
  input  logic   clk,
  input  logic   reset,
  Axis_If.slave  freq,
  Axis_If.master data_out
);
  localparam int DW       = 24;
  localparam int LUT_SIZE = 1 << LUT_BITS;
  localparam logic [63:0] INC_MULT =
    ((64'd1 << (PHASE_BITS + 7)) + 64'(SAMPLE_RATE_HZ / 2)) / 64'(SAMPLE_RATE_HZ);
  localparam logic [32:0] CLK_RATE    = 33'(CLK_RATE_HZ);
  localparam logic [32:0] SAMPLE_RATE = 33'(SAMPLE_RATE_HZ);

  function automatic logic [DW-1:0] sine_entry(input int k);
    real v;
    v = real'((1 << (DW - 1)) - 1) * $sin(6.283185307179586 * real'(k) / real'(LUT_SIZE));
    if (v < 0.0) return DW'(-$rtoi(0.5 - v));
    return DW'($rtoi(v + 0.5));
  endfunction

  logic [DW-1:0] w_lut [LUT_SIZE];
  for (genvar k = 0; k < LUT_SIZE; k++) begin : g_rom
    localparam logic [DW-1:0] ENTRY = sine_entry(k);
    assign w_lut[k] = ENTRY;
  end

  logic [DW-1:0]         r_freq;
  logic [PHASE_BITS-1:0] r_inc;
  logic [PHASE_BITS-1:0] r_phase;
  logic [31:0]           r_acc;
  logic                  r_valid;
  logic [DW-1:0]         r_data;

  logic [63:0]           w_prod;
  logic [32:0]           w_acc_sum;
  logic                  w_strobe;
  logic [LUT_BITS-1:0]   w_idx;

  always_comb begin
    w_prod    = 64'(r_freq) * INC_MULT;
    w_acc_sum = {1'b0, r_acc} + SAMPLE_RATE;
    w_strobe  = (w_acc_sum >= CLK_RATE);
    w_idx     = r_phase[PHASE_BITS-1 -: LUT_BITS];
  end

  assign freq.ready     = ~reset;
  assign data_out.data  = r_data;
  assign data_out.valid = r_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_freq  <= '0;
      r_inc   <= '0;
      r_phase <= '0;
      r_acc   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      if (freq.valid && freq.ready) r_freq <= freq.data;
      r_inc <= PHASE_BITS'(w_prod >> 16);
      // A strobe overwrites any unaccepted sample; valid then simply stays high.
      if (w_strobe) begin
        r_acc   <= 32'(w_acc_sum - CLK_RATE);
        r_phase <= r_phase + r_inc;
        r_data  <= w_lut[w_idx];
        r_valid <= 1'b1;
      end else begin
        r_acc <= w_acc_sum[31:0];
        if (r_valid && data_out.ready) r_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_wavetable.sv
// Directed bench for wavetable; a 1 MHz clock rate keeps the 48 kHz strobe
// fractional (20/21-cycle spacing) while keeping runs short.
module tb_wavetable;
  localparam logic [63:0] MULT = 64'd11453246;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int errors = 0;
  int checks = 0;

  Axis_If #(.DWIDTH(24)) freq_if ();
  Axis_If #(.DWIDTH(24)) out_if ();

  wavetable #(
    .CLK_RATE_HZ   (1_000_000),
    .SAMPLE_RATE_HZ(48_000),
    .PHASE_BITS    (32),
    .LUT_BITS      (10)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .freq    (freq_if),
    .data_out(out_if)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] lut_ref(input logic [9:0] idx);
    real a;
    a = 8388607.0 * $sin(2.0 * 3.141592653589793 * real'(idx) / 1024.0);
    return 24'($rtoi($floor(a + 0.5)));
  endfunction

  function automatic logic [31:0] inc_ref(input logic [23:0] f);
    logic [63:0] p;
    p = {40'd0, f} * MULT;
    return p[47:16];
  endfunction

  task automatic apply_reset(input int n);
    reset = 1'b1;
    freq_if.valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic send_freq(input logic [23:0] f);
    freq_if.data  = f;
    freq_if.valid = 1'b1;
    @(posedge clk);
    #1;
    freq_if.valid = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    int i;
    ok = 1'b0;
    i  = 0;
    while (!ok && i < 50) begin
      @(posedge clk);
      #1;
      ok = out_if.valid;
      i++;
    end
  endtask

  task automatic test_reset();
    int  n;
    bit  seen;
    reset = 1'b1;
    freq_if.valid = 1'b0;
    freq_if.data  = '0;
    out_if.ready  = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_if.valid !== 1'b0 || out_if.data !== 24'd0 || freq_if.ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: valid=%b data=%h ready=%b, required 0/000000/0",
                 c, out_if.valid, out_if.data, freq_if.ready);
      end
    end
    reset = 1'b0;
    #1;
    checks++;
    if (freq_if.ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_release: got %b required 1", freq_if.ready);
    end
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      seen = out_if.valid;
    end
    checks++;
    if (!seen || n != 21) begin
      errors++;
      $display("FAIL first_strobe: valid after %0d cycles (seen=%b), required 21", n, seen);
    end
    checks++;
    if (out_if.data !== 24'd0) begin
      errors++;
      $display("FAIL first_sample: got %h required 000000", out_if.data);
    end
  endtask

  task automatic test_zero_freq();
    int cnt, bad;
    apply_reset(1);
    out_if.ready = 1'b1;
    cnt = 0;
    bad = 0;
    for (int c = 0; c < 10000; c++) begin
      @(posedge clk);
      #1;
      if (out_if.valid === 1'b1) begin
        cnt++;
        if (out_if.data !== 24'd0) bad++;
      end
    end
    checks++;
    if (cnt != 480) begin
      errors++;
      $display("FAIL zero_freq_count: got %0d samples required 480", cnt);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL zero_freq_data: got %0d nonzero samples required 0", bad);
    end
  endtask

  task automatic test_tone();
    bit          ok;
    logic [31:0] inc, ph;
    logic [23:0] exp_d, s12, s36;
    apply_reset(1);
    out_if.ready = 1'b1;
    send_freq(24'd512000);
    inc = inc_ref(24'd512000);
    s12 = '0;
    s36 = '0;
    for (int n = 0; n < 50; n++) begin
      wait_valid(ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL tone_timeout sample %0d: no valid within 50 cycles, required valid", n);
      end
      ph = 32'(n) * inc;
      exp_d = lut_ref(ph[31:22]);
      checks++;
      if (out_if.data !== exp_d) begin
        errors++;
        $display("FAIL tone sample %0d: got %h required %h", n, out_if.data, exp_d);
      end
      if (n == 12) s12 = out_if.data;
      if (n == 36) s36 = out_if.data;
    end
    checks++;
    if (s12 !== 24'h7FFF61) begin
      errors++;
      $display("FAIL tone_peak sample 12: got %h required 7fff61", s12);
    end
    checks++;
    if (s36 !== 24'h80009F) begin
      errors++;
      $display("FAIL tone_trough sample 36: got %h required 80009f", s36);
    end
  endtask

  // Follows test_tone: sample 49 is pending when ready drops.
  task automatic test_backpressure();
    int          drops, xfers;
    logic [31:0] ph;
    logic [23:0] exp_d;
    out_if.ready = 1'b0;
    drops = 0;
    for (int c = 0; c < 70; c++) begin
      @(posedge clk);
      #1;
      if (out_if.valid !== 1'b1) drops++;
    end
    checks++;
    if (drops != 0) begin
      errors++;
      $display("FAIL bp_valid_held: valid low in %0d cycles, required 0", drops);
    end
    ph = 32'(52) * inc_ref(24'd512000);
    exp_d = lut_ref(ph[31:22]);
    checks++;
    if (out_if.data !== exp_d) begin
      errors++;
      $display("FAIL bp_data: got %h required %h (third overwrite)", out_if.data, exp_d);
    end
    out_if.ready = 1'b1;
    xfers = 0;
    for (int c = 0; c < 6; c++) begin
      if (out_if.valid === 1'b1) xfers++;
      @(posedge clk);
      #1;
      if (c == 0) begin
        checks++;
        if (out_if.valid !== 1'b0) begin
          errors++;
          $display("FAIL bp_valid_clear: got %b required 0", out_if.valid);
        end
      end
    end
    checks++;
    if (xfers != 1) begin
      errors++;
      $display("FAIL bp_transfers: got %0d required 1", xfers);
    end
  endtask

  task automatic test_midreset();
    bit          ok;
    logic [31:0] inc, ph;
    logic [23:0] exp_d;
    out_if.ready = 1'b0;
    wait_valid(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL midreset_pending: no pending sample, required valid");
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_if.valid !== 1'b0 || out_if.data !== 24'd0 || freq_if.ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_state: valid=%b data=%h ready=%b, required 0/000000/0",
               out_if.valid, out_if.data, freq_if.ready);
    end
    reset = 1'b0;
    out_if.ready = 1'b1;
    send_freq(24'd512000);
    inc = inc_ref(24'd512000);
    for (int n = 0; n < 6; n++) begin
      wait_valid(ok);
      ph = 32'(n) * inc;
      exp_d = lut_ref(ph[31:22]);
      checks++;
      if (!ok || out_if.data !== exp_d) begin
        errors++;
        $display("FAIL midreset_restart sample %0d: got %h (valid=%b) required %h",
                 n, out_if.data, ok, exp_d);
      end
    end
  endtask

  task automatic test_alias();
    bit          ok;
    logic [31:0] inc, ph;
    logic [23:0] exp_d;
    apply_reset(1);
    out_if.ready = 1'b1;
    send_freq(24'd15360000);
    inc = inc_ref(24'd15360000);
    for (int n = 0; n < 20; n++) begin
      wait_valid(ok);
      ph = 32'(n) * inc;
      exp_d = lut_ref(ph[31:22]);
      checks++;
      if (!ok || out_if.data !== exp_d) begin
        errors++;
        $display("FAIL alias_30k sample %0d: got %h (valid=%b) required %h",
                 n, out_if.data, ok, exp_d);
      end
    end
  endtask

  // Frequency ramp: a strobe at edge c uses the increment derived from the
  // frequency register as it stood after edge c-2.
  task automatic test_ramp();
    logic [23:0] f0, f1, f2, fcur;
    logic [31:0] ph;
    logic [23:0] exp_d;
    bit          drove;
    int          nsamp;
    apply_reset(1);
    out_if.ready = 1'b1;
    f0 = '0; f1 = '0; f2 = '0;
    fcur = 24'd512;
    ph = '0;
    nsamp = 0;
    for (int c = 1; c <= 3000; c++) begin
      drove = ((c - 1) % 100 == 0);
      if (drove) begin
        freq_if.data  = fcur;
        freq_if.valid = 1'b1;
      end
      @(posedge clk);
      #1;
      freq_if.valid = 1'b0;
      f2 = f1;
      f1 = f0;
      if (drove) begin
        f0 = fcur;
        fcur = fcur + 24'd512;
      end
      if (out_if.valid === 1'b1) begin
        exp_d = lut_ref(ph[31:22]);
        checks++;
        if (out_if.data !== exp_d) begin
          errors++;
          $display("FAIL ramp sample %0d at cycle %0d: got %h required %h",
                   nsamp, c, out_if.data, exp_d);
        end
        ph = ph + inc_ref(f2);
        nsamp++;
      end
    end
    checks++;
    if (nsamp != 144) begin
      errors++;
      $display("FAIL ramp_count: got %0d samples required 144", nsamp);
    end
  endtask

  initial begin
    freq_if.valid = 1'b0;
    freq_if.data  = '0;
    out_if.ready  = 1'b1;
    test_reset();
    test_zero_freq();
    test_tone();
    test_backpressure();
    test_midreset();
    test_alias();
    test_ramp();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wavetable.md
WAVETABLE -- requirements
Module: wavetable

Interface
REQ-001 Parameter CLK_RATE_HZ, 100_000_000: system clock frequency.
REQ-002 Parameter SAMPLE_RATE_HZ, 48_000: output sample rate.
REQ-003 Parameter PHASE_BITS, 32: phase accumulator width.
REQ-004 Parameter LUT_BITS, 10: sine table address width (1024 entries).
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 freq  Axis_If slave (modport), DWIDTH=24  requested tone frequency; unsigned Q15.9 Hz (1 Hz = 24'd512); signals data, valid, ready.
REQ-008 data_out  Axis_If master (modport), DWIDTH=24  signed two's-complement sine samples; signals data, valid, ready.

Function
REQ-009 freq.ready SHALL be 1 in every cycle reset is low, 0 while reset is high.
REQ-010 On freq.valid && freq.ready, freq_reg SHALL load freq.data; with no handshake, freq_reg holds its value.
REQ-011 inc_reg SHALL be registered each cycle as (freq_reg * INC_MULT) >> 16, INC_MULT = round(2^(PHASE_BITS+7) / SAMPLE_RATE_HZ) (11453246 at defaults); full-width product, truncated to PHASE_BITS.
REQ-012 Sample strobe: accumulator adds SAMPLE_RATE_HZ every cycle; when sum >= CLK_RATE_HZ, subtract CLK_RATE_HZ and assert strobe for one cycle (exact average rate, 2083/2084-cycle spacing).
REQ-013 On strobe, phase SHALL advance phase <= phase + inc_reg modulo 2^PHASE_BITS; no other phase updates.
REQ-014 LUT entry k SHALL equal round((2^23-1) * sin(2*pi*k/2^LUT_BITS)), computed at elaboration; ROM, no runtime writes.
REQ-015 On strobe in cycle t, data_out.data SHALL be LUT[phase[PHASE_BITS-1 -: LUT_BITS]] using pre-update phase; data_out.valid = 1 from t+1 (latency 1 cycle).
REQ-016 data_out.valid SHALL clear the cycle after valid && ready unless a new strobe loads a sample that cycle (valid stays 1).
REQ-017 Backpressure: if valid && !ready when a new strobe occurs, the register SHALL be overwritten by the new sample (old dropped); valid stays 1; data stable otherwise.
REQ-018 Frequency change: phase accumulator SHALL NOT reset; waveform phase-continuous; new inc_reg used from the first strobe >= 2 cycles after freq handshake.
REQ-019 Frequencies >= SAMPLE_RATE_HZ/2 SHALL alias naturally; no clamping or saturation.
REQ-020 Wrap-around of phase and strobe accumulators SHALL be silent and modular.

Reset
REQ-021 During reset: freq_reg=0, inc_reg=0, phase=0, strobe accumulator=0, data_out.valid=0, data_out.data=0, freq.ready=0.
REQ-022 Reset asserted mid-stream SHALL take effect next edge, discarding a pending output sample; first sample after release is LUT[0]=0.
REQ-023 First strobe after reset release SHALL occur after the accumulator first reaches CLK_RATE_HZ (cycle 2084 at defaults).

Verification
REQ-024 Hold reset 500 cycles -> data_out.valid=0, data_out.data=0, freq.ready=0 throughout; freq.ready=1 next cycle after release.
REQ-025 freq=0, ready=1, run 1_000_000 cycles -> exactly 480 valid samples, all data=0.
REQ-026 freq=24'd512000 (1000 Hz) -> inc_reg=89478485; sample n = LUT[(n*89478485 mod 2^32)>>22]; sample 12 = LUT[255] (≈ +8388449); sample 36 ≈ negative peak; period 48 samples.
REQ-027 data_out.ready=0 across 3 strobes then 1 -> valid stays 1, data equals third sample, exactly one transfer, valid drops next cycle.
REQ-028 Step freq 1 Hz/us (+512 per 100 cycles) for 10 ms -> no phase discontinuity: successive sample indices differ by floor/ceil of inc_reg>>22 only.
REQ-029 Assert reset 1 cycle mid-stream at 1000 Hz -> pending sample dropped, next valid sample = 0, sequence restarts per REQ-026.
